// File: rtl/pulse_meas_pkg.sv
// Shared types and helpers for the pulse-width meter.
// Pure definitions, no clocked logic.
package pulse_meas_pkg;

   typedef enum logic {MODE_WINDOW = 1'b0, MODE_SINGLE = 1'b1} mode_e;

   typedef enum logic [0:0] {ST_ARMED = 1'b0, ST_MEAS = 1'b1} ch_state_e;

   localparam int unsigned MAX_CNT_W = 32;

   // Increment that sticks at the all-ones value of a width-bit counter.
   function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] val,
                                                    input int unsigned          width);
      logic [MAX_CNT_W-1:0] max_val;
      if (width >= MAX_CNT_W)
         max_val = '1;
      else
         max_val = (MAX_CNT_W'(1) << width) - MAX_CNT_W'(1);
      sat_inc = (val >= max_val) ? max_val : val + MAX_CNT_W'(1);
   endfunction

endpackage

// File: rtl/pulse_meas_ch.sv
// One channel: synchroniser, edge detect, saturating counter, SINGLE-mode FSM, result + handshake.
// Latency: SYNC_STAGES to p_s, result one cycle after capture; no backpressure, overrun flags lost results.
module pulse_meas_ch
   import pulse_meas_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk_sys,
   input  logic             rst_n,
   input  logic             pulse_in,
   input  mode_e            mode,
   input  logic             window_strobe,
   input  logic             clr,
   input  logic             res_ack,
   output logic [CNT_W-1:0] result,
   output logic             res_valid,
   output logic             sat,
   output logic             overrun
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   p_s, p_d, rise, fall;
   logic [CNT_W-1:0]       cnt, cnt_nxt, cnt_inc;
   ch_state_e              st, st_nxt;
   logic                   capture;

   assign p_s     = sync_q[SYNC_STAGES-1];
   assign rise    = p_s & ~p_d;
   assign fall    = ~p_s & p_d;
   assign cnt_inc = CNT_W'(sat_inc(MAX_CNT_W'(cnt), CNT_W));

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         p_d    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
         p_d    <= p_s;
      end
   end

   always_comb begin
      capture = 1'b0;
      cnt_nxt = cnt;
      st_nxt  = st;
      if (clr) begin
         cnt_nxt = '0;
         st_nxt  = ST_ARMED;
      end else if (mode == MODE_WINDOW) begin
         // Reload with the current sample so the strobe cycle's high time lands in the next window.
         if (window_strobe) begin
            capture = 1'b1;
            cnt_nxt = CNT_W'(p_s);
         end else if (p_s) begin
            cnt_nxt = cnt_inc;
         end
      end else begin
         case (st)
            ST_ARMED: begin
               cnt_nxt = '0;
               if (rise) begin
                  st_nxt  = ST_MEAS;
                  cnt_nxt = CNT_W'(1);
               end
            end
            default: begin
               if (fall) begin
                  capture = 1'b1;
                  cnt_nxt = '0;
                  st_nxt  = ST_ARMED;
               end else if (p_s) begin
                  cnt_nxt = cnt_inc;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         st        <= ST_ARMED;
         result    <= '0;
         res_valid <= 1'b0;
         sat       <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         st  <= st_nxt;
         if (capture) begin
            result    <= cnt;
            sat       <= (cnt == CNT_MAX);
            res_valid <= 1'b1;
            // A same-cycle ack consumes the old result, so only an unacked one counts as lost.
            if (res_ack)
               overrun <= 1'b0;
            else if (res_valid)
               overrun <= 1'b1;
         end else if (res_ack && res_valid) begin
            res_valid <= 1'b0;
            overrun   <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pulse_width_meter.sv
// Multi-channel pulse-width / high-time meter: mode-change detector plus N_CH channel instances.
// Latency: SYNC_STAGES in, one cycle capture-to-output; no backpressure, per-channel overrun flag.
module pulse_width_meter
   import pulse_meas_pkg::*;
#(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk_sys,
   input  logic                  rst_n,
   input  logic [N_CH-1:0]       pulse_in,
   input  logic                  mode,
   input  logic                  window_strobe,
   output logic [N_CH*CNT_W-1:0] result,
   output logic [N_CH-1:0]       res_valid,
   input  logic [N_CH-1:0]       res_ack,
   output logic [N_CH-1:0]       sat,
   output logic [N_CH-1:0]       overrun
);

   mode_e mode_q, mode_prev;
   logic  mode_chg;

   // A registered mode edge clears every channel on the following cycle.
   assign mode_chg = (mode_q != mode_prev);

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         mode_q    <= MODE_WINDOW;
         mode_prev <= MODE_WINDOW;
      end else begin
         mode_q    <= mode_e'(mode);
         mode_prev <= mode_q;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      pulse_meas_ch #(
         .CNT_W       (CNT_W),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
         .clk_sys       (clk_sys),
         .rst_n         (rst_n),
         .pulse_in      (pulse_in[i]),
         .mode          (mode_q),
         .window_strobe (window_strobe),
         .clr           (mode_chg),
         .res_ack       (res_ack[i]),
         .result        (result[i*CNT_W +: CNT_W]),
         .res_valid     (res_valid[i]),
         .sat           (sat[i]),
         .overrun       (overrun[i])
      );
   end

endmodule
